// File: rtl/wb_fifo_arbiter_pkg.sv
// Shared writeback-arbiter constants: source count, data width and the
// per-execution-unit source indices seen on wb_src_id.
package wb_fifo_arbiter_pkg;

   localparam int WB_NUM_SOURCES = 4;
   localparam int WB_DATA_WIDTH  = 32;

   typedef logic [$clog2(WB_NUM_SOURCES)-1:0] wb_src_id_t;

   localparam wb_src_id_t WB_SRC_ALU = wb_src_id_t'(0);
   localparam wb_src_id_t WB_SRC_LS  = wb_src_id_t'(1);
   localparam wb_src_id_t WB_SRC_MUL = wb_src_id_t'(2);
   localparam wb_src_id_t WB_SRC_DIV = wb_src_id_t'(3);

endpackage

// File: rtl/wb_fifo_arbiter_if.sv
// Bundle of source-FIFO views plus the shared writeback port. The master
// modport is the arbiter; the slave modport is the FIFOs and the consumer.
interface wb_fifo_arbiter_if #(
   parameter int NUM_SOURCES = wb_fifo_arbiter_pkg::WB_NUM_SOURCES,
   parameter int DATA_WIDTH  = wb_fifo_arbiter_pkg::WB_DATA_WIDTH
);
   logic [NUM_SOURCES-1:0]                 src_valid;
   logic [NUM_SOURCES-1:0][DATA_WIDTH-1:0] src_data;
   logic [NUM_SOURCES-1:0]                 src_enable;
   logic [NUM_SOURCES-1:0]                 src_pop;
   logic                                   wb_valid;
   logic [DATA_WIDTH-1:0]                  wb_data;
   logic [$clog2(NUM_SOURCES)-1:0]         wb_src_id;
   logic                                   wb_ready;

   modport master (
      input  src_valid, src_data, src_enable, wb_ready,
      output src_pop, wb_valid, wb_data, wb_src_id
   );

   modport slave (
      output src_valid, src_data, src_enable, wb_ready,
      input  src_pop, wb_valid, wb_data, wb_src_id
   );
endinterface

// File: rtl/wb_fifo_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set req bit strictly after
// last_grant, wrapping to index 0.
module rr_priority_picker
   import wb_fifo_arbiter_pkg::*;
#(
   parameter int NUM_SOURCES = WB_NUM_SOURCES,
   localparam int IDW        = $clog2(NUM_SOURCES)
) (
   input  logic [NUM_SOURCES-1:0] req,
   input  logic [IDW-1:0]         last_grant,
   output logic [NUM_SOURCES-1:0] grant_oh,
   output logic [IDW-1:0]         grant_idx,
   output logic                   any_req
);
   logic [NUM_SOURCES-1:0]   upper_mask;
   logic [2*NUM_SOURCES-1:0] dbl_req;

   always_comb begin
      upper_mask = '0;
      for (int i = 0; i < NUM_SOURCES; i++)
         upper_mask[i] = (i > int'(last_grant));
      // Low half only holds requests above last_grant, so the lowest set
      // bit of the doubled vector is the next source in rotation order.
      dbl_req = {req, req & upper_mask};
      grant_idx = '0;
      for (int i = 2*NUM_SOURCES-1; i >= 0; i--)
         if (dbl_req[i]) grant_idx = IDW'(i % NUM_SOURCES);
      any_req  = |req;
      grant_oh = '0;
      for (int i = 0; i < NUM_SOURCES; i++)
         grant_oh[i] = any_req && (grant_idx == IDW'(i));
   end
endmodule

// File: rtl/wb_fifo_arbiter.sv
// Round-robin drain of several result FIFOs into one registered writeback
// port; the pop and the capture of the granted head happen in the same cycle.
module wb_fifo_arbiter
   import wb_fifo_arbiter_pkg::*;
#(
   parameter int NUM_SOURCES = WB_NUM_SOURCES,
   parameter int DATA_WIDTH  = WB_DATA_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   wb_fifo_arbiter_if.master bus
);
   localparam int IDW = $clog2(NUM_SOURCES);

   logic [NUM_SOURCES-1:0] req;
   logic [NUM_SOURCES-1:0] grant_oh;
   logic [IDW-1:0]         grant_idx;
   logic                   any_req;
   logic                   load_en;

   logic                  wb_valid_q,   wb_valid_d;
   logic [DATA_WIDTH-1:0] wb_data_q,    wb_data_d;
   logic [IDW-1:0]        wb_src_id_q,  wb_src_id_d;
   logic [IDW-1:0]        last_grant_q, last_grant_d;

   assign req = bus.src_valid & bus.src_enable;

   rr_priority_picker #(.NUM_SOURCES(NUM_SOURCES)) u_picker (
      .req        (req),
      .last_grant (last_grant_q),
      .grant_oh   (grant_oh),
      .grant_idx  (grant_idx),
      .any_req    (any_req)
   );

   // Load when the port is empty or its entry leaves this same cycle.
   assign load_en     = any_req && (!wb_valid_q || bus.wb_ready);
   assign bus.src_pop = (load_en && !rst) ? grant_oh : '0;

   always_comb begin
      wb_valid_d   = wb_valid_q;
      wb_data_d    = wb_data_q;
      wb_src_id_d  = wb_src_id_q;
      last_grant_d = last_grant_q;
      if (load_en) begin
         wb_valid_d   = 1'b1;
         wb_data_d    = bus.src_data[grant_idx];
         wb_src_id_d  = grant_idx;
         last_grant_d = grant_idx;
      end else if (wb_valid_q && bus.wb_ready) begin
         wb_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid_q   <= 1'b0;
         wb_data_q    <= '0;
         wb_src_id_q  <= '0;
         last_grant_q <= IDW'(NUM_SOURCES-1);
      end else begin
         wb_valid_q   <= wb_valid_d;
         wb_data_q    <= wb_data_d;
         wb_src_id_q  <= wb_src_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign bus.wb_valid  = wb_valid_q;
   assign bus.wb_data   = wb_data_q;
   assign bus.wb_src_id = wb_src_id_q;
endmodule

// File: tb/tb_wb_fifo_arbiter.sv
// Randomized scoreboard bench for wb_fifo_arbiter: a per-cycle reference model
// predicts pops and writeback entries, and a monitor compares them on negedge.
module tb_wb_fifo_arbiter;
   import wb_fifo_arbiter_pkg::*;

   localparam int N = 4;
   localparam int W = 32;

   typedef struct {
      logic [N-1:0] pop;
      logic         valid;
      logic         ready;
      logic         chk_zero;
      logic         flush;
   } cyc_t;

   typedef struct {
      logic [W-1:0] data;
      wb_src_id_t   id;
   } ent_t;

   logic clk;
   logic rst;

   wb_fifo_arbiter_if #(.NUM_SOURCES(N), .DATA_WIDTH(W)) bus ();

   wb_fifo_arbiter #(.NUM_SOURCES(N), .DATA_WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   cyc_t cyc_q[$];
   ent_t ent_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   bit   m_held  = 1'b0;
   bit   m_fresh = 1'b1;
   int   m_last  = N-1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Next requester after 'last' in circular order, or -1 when none request.
   function automatic int rr_pick(input logic [N-1:0] req, input int last);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (last + k) % N;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] en,
                        input logic rdy, input logic r, input bit fix0);
      cyc_t         c;
      ent_t         e;
      int           g;
      logic [N-1:0] req;
      bit           load;
      @(posedge clk);
      #2;
      rst            = r;
      bus.src_valid  = v;
      bus.src_enable = en;
      bus.wb_ready   = rdy;
      for (int i = 0; i < N; i++) bus.src_data[i] = $urandom;
      if (fix0) bus.src_data[0] = 32'hA5A5_0001;
      c.valid    = m_held;
      c.ready    = rdy;
      c.chk_zero = m_fresh;
      c.flush    = r;
      c.pop      = '0;
      if (r) begin
         m_held  = 1'b0;
         m_last  = N-1;
         m_fresh = 1'b1;
      end else begin
         req  = v & en;
         g    = rr_pick(req, m_last);
         load = (g >= 0) && (!m_held || rdy);
         if (load) begin
            c.pop  = N'(1 << g);
            e.data = bus.src_data[g];
            e.id   = wb_src_id_t'(g);
            ent_q.push_back(e);
            m_last  = g;
            m_held  = 1'b1;
            m_fresh = 1'b0;
         end else if (m_held && rdy) begin
            m_held = 1'b0;
         end
      end
      cyc_q.push_back(c);
   endtask

   initial begin
      cyc_t c;
      ent_t e;
      forever begin
         @(negedge clk);
         if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            check("src_pop", 64'(bus.src_pop), 64'(c.pop));
            check("wb_valid", 64'(bus.wb_valid), 64'(c.valid));
            if (c.chk_zero) begin
               check("reset_wb_data", 64'(bus.wb_data), 64'(0));
               check("reset_wb_src_id", 64'(bus.wb_src_id), 64'(0));
            end
            if (c.valid) begin
               if (ent_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL wb_entry: port held with no entry predicted at %0t", $time);
               end else begin
                  e = ent_q[0];
                  check("wb_data", 64'(bus.wb_data), 64'(e.data));
                  check("wb_src_id", 64'(bus.wb_src_id), 64'(e.id));
                  if (c.ready) void'(ent_q.pop_front());
               end
            end
            if (c.flush) ent_q.delete();
         end
      end
   end

   initial begin
      rst            = 1'b1;
      bus.src_valid  = '0;
      bus.src_enable = '0;
      bus.src_data   = '0;
      bus.wb_ready   = 1'b0;

      // Reset with every source requesting: no pops may leak out.
      drive(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0);
      drive(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0);
      drive(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);

      // Single source, then an idle cycle to observe it.
      drive(4'b0001, 4'b1111, 1'b1, 1'b0, 1'b1);
      drive(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);

      // Round-robin with all sources requesting.
      for (int i = 0; i < 8; i++) drive(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
      drive(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);

      // Backpressure on a held source-2 entry, release grants source 3.
      drive(4'b0100, 4'b1111, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
      drive(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);

      // Enable mask 1010 starting from last_grant=3.
      for (int i = 0; i < 4; i++) drive(4'b1111, 4'b1010, 1'b1, 1'b0, 1'b0);

      // Drain to empty from source 1.
      drive(4'b0010, 4'b1111, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);

      // Mid-operation reset with a held source-2 entry.
      drive(4'b0100, 4'b1111, 1'b1, 1'b0, 1'b0);
      drive(4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0);
      drive(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
      drive(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);

      // Random traffic with occasional masks, stalls and resets.
      for (int i = 0; i < 3000; i++) begin
         logic [N-1:0] v, en;
         logic         rdy, r;
         v   = N'($urandom);
         en  = ($urandom_range(0, 3) == 0) ? N'($urandom) : {N{1'b1}};
         rdy = ($urandom_range(0, 3) != 0);
         r   = ($urandom_range(0, 199) == 0);
         drive(v, en, rdy, r, 1'b0);
      end

      drive(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
      drive(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
